// File: rtl/sw_acc_mr_rsp_arbiter.sv
// -----------------------------------------------------------------------------
// sw_acc_mr_rsp_arbiter
//
// Merges the response packet streams of the MPT, MTT and ICM-mapping worker
// threads into a single response stream back to the CEU.
//
// Arbitration is round-robin at packet granularity. A source that wins keeps
// the output until its last beat has been accepted. Each packet costs exactly
// one decision cycle in IDLE, during which no beat is accepted. One registered
// output stage sits between the winning source and the CEU, so every beat
// accepted in cycle N appears on ceu_rsp_* in cycle N+1.
//
// Optional feature (macro SW_ACC_MR_RSP_CNT_EN):
//   Adds mpt_pkt_cnt / mtt_pkt_cnt / mapping_pkt_cnt, each counting the
//   completed packets (last beat accepted) of its source. The counters wrap
//   and are cleared by reset. Without the macro the ports and counters are
//   absent and the datapath and timing are unchanged.
//
// Ports
//   clk, rst                 clock, synchronous active-low reset (0 = reset)
//   mpt_rsp_*                MPT source: valid/head/last/data in, ready out
//   mtt_rsp_*                MTT source, same shape
//   mapping_rsp_*            ICM-mapping source, same shape
//   ceu_rsp_valid/head/last/data  registered merged stream to the CEU
//   ceu_rsp_ready            CEU accepts the beat on ceu_rsp_*
//   *_pkt_cnt                per-source packet counters (optional)
// -----------------------------------------------------------------------------
module sw_acc_mr_rsp_arbiter #(
  parameter int HEAD_WIDTH = 128,
  parameter int DATA_WIDTH = 256,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  mpt_rsp_valid,
  input  logic [HEAD_WIDTH-1:0] mpt_rsp_head,
  input  logic                  mpt_rsp_last,
  input  logic [DATA_WIDTH-1:0] mpt_rsp_data,
  output logic                  mpt_rsp_ready,

  input  logic                  mtt_rsp_valid,
  input  logic [HEAD_WIDTH-1:0] mtt_rsp_head,
  input  logic                  mtt_rsp_last,
  input  logic [DATA_WIDTH-1:0] mtt_rsp_data,
  output logic                  mtt_rsp_ready,

  input  logic                  mapping_rsp_valid,
  input  logic [HEAD_WIDTH-1:0] mapping_rsp_head,
  input  logic                  mapping_rsp_last,
  input  logic [DATA_WIDTH-1:0] mapping_rsp_data,
  output logic                  mapping_rsp_ready,

  output logic                  ceu_rsp_valid,
  output logic [HEAD_WIDTH-1:0] ceu_rsp_head,
  output logic                  ceu_rsp_last,
  output logic [DATA_WIDTH-1:0] ceu_rsp_data,
  input  logic                  ceu_rsp_ready
`ifdef SW_ACC_MR_RSP_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  mpt_pkt_cnt,
  output logic [CNT_WIDTH-1:0]  mtt_pkt_cnt,
  output logic [CNT_WIDTH-1:0]  mapping_pkt_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GRANT_MPT = 2'd1,
    GRANT_MTT = 2'd2,
    GRANT_MAP = 2'd3
  } state_t;

  // Source indices used by the round-robin pointer.
  localparam logic [1:0] SRC_MPT = 2'd0;
  localparam logic [1:0] SRC_MTT = 2'd1;
  localparam logic [1:0] SRC_MAP = 2'd2;

  state_t                state;
  state_t                state_nxt;
  logic [1:0]            rr;
  logic [1:0]            rr_nxt;

  logic [2:0]            req;
  logic [1:0]            winner;
  logic                  out_free;
  logic                  accept;
  logic                  sel_valid;
  logic                  sel_last;
  logic [HEAD_WIDTH-1:0] sel_head;
  logic [DATA_WIDTH-1:0] sel_data;

  // Pick the first requesting source, starting the search at the pointer and
  // wrapping MPT -> MTT -> MAP -> MPT. Only meaningful when req is non-zero.
  function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] ptr);
    logic [1:0] w;
    case (ptr)
      SRC_MTT: w = r[1] ? SRC_MTT : (r[2] ? SRC_MAP : SRC_MPT);
      SRC_MAP: w = r[2] ? SRC_MAP : (r[0] ? SRC_MPT : SRC_MTT);
      default: w = r[0] ? SRC_MPT : (r[1] ? SRC_MTT : SRC_MAP);
    endcase
    return w;
  endfunction

  // Pointer moves to the source just after the winner.
  function automatic logic [1:0] rr_after(input logic [1:0] w);
    logic [1:0] n;
    case (w)
      SRC_MPT: n = SRC_MTT;
      SRC_MTT: n = SRC_MAP;
      default: n = SRC_MPT;
    endcase
    return n;
  endfunction

  assign req      = {mapping_rsp_valid, mtt_rsp_valid, mpt_rsp_valid};
  assign winner   = rr_pick(req, rr);
  // The output stage can take a beat if it is empty or being drained now.
  assign out_free = !ceu_rsp_valid || ceu_rsp_ready;

  // State and round-robin pointer registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      rr    <= SRC_MPT;
    end else begin
      state <= state_nxt;
      rr    <= rr_nxt;
    end
  end

  // Next-state, per-source ready and granted-source mux.
  always_comb begin
    state_nxt         = state;
    rr_nxt            = rr;
    mpt_rsp_ready     = 1'b0;
    mtt_rsp_ready     = 1'b0;
    mapping_rsp_ready = 1'b0;
    sel_valid         = 1'b0;
    sel_last          = 1'b0;
    sel_head          = '0;
    sel_data          = '0;

    case (state)
      IDLE: begin
        // Decision cycle: nothing is accepted here.
        if (|req) begin
          rr_nxt = rr_after(winner);
          case (winner)
            SRC_MPT: state_nxt = GRANT_MPT;
            SRC_MTT: state_nxt = GRANT_MTT;
            default: state_nxt = GRANT_MAP;
          endcase
        end else begin
          state_nxt = IDLE;
        end
      end
      GRANT_MPT: begin
        mpt_rsp_ready = out_free;
        sel_valid     = mpt_rsp_valid;
        sel_last      = mpt_rsp_last;
        sel_head      = mpt_rsp_head;
        sel_data      = mpt_rsp_data;
      end
      GRANT_MTT: begin
        mtt_rsp_ready = out_free;
        sel_valid     = mtt_rsp_valid;
        sel_last      = mtt_rsp_last;
        sel_head      = mtt_rsp_head;
        sel_data      = mtt_rsp_data;
      end
      GRANT_MAP: begin
        mapping_rsp_ready = out_free;
        sel_valid         = mapping_rsp_valid;
        sel_last          = mapping_rsp_last;
        sel_head          = mapping_rsp_head;
        sel_data          = mapping_rsp_data;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Grant is released only once the final beat has actually been taken;
    // a valid gap from the granted source just produces bubbles.
    if ((state != IDLE) && sel_valid && out_free && sel_last) begin
      state_nxt = IDLE;
    end else begin
      state_nxt = state_nxt;
    end
  end

  assign accept = (state != IDLE) && sel_valid && out_free;

  // Registered output stage: load on accept, empty when drained with no refill.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ceu_rsp_valid <= 1'b0;
      ceu_rsp_head  <= '0;
      ceu_rsp_last  <= 1'b0;
      ceu_rsp_data  <= '0;
    end else if (accept) begin
      ceu_rsp_valid <= 1'b1;
      ceu_rsp_head  <= sel_head;
      ceu_rsp_last  <= sel_last;
      ceu_rsp_data  <= sel_data;
    end else if (ceu_rsp_ready) begin
      ceu_rsp_valid <= 1'b0;
    end
  end

`ifdef SW_ACC_MR_RSP_CNT_EN
  logic pkt_done;
  assign pkt_done = accept && sel_last;

  // Completed-packet counters, one per source; natural wrap at full scale.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mpt_pkt_cnt     <= '0;
      mtt_pkt_cnt     <= '0;
      mapping_pkt_cnt <= '0;
    end else if (pkt_done) begin
      case (state)
        GRANT_MPT: mpt_pkt_cnt     <= mpt_pkt_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        GRANT_MTT: mtt_pkt_cnt     <= mtt_pkt_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        GRANT_MAP: mapping_pkt_cnt <= mapping_pkt_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        default:   mpt_pkt_cnt     <= mpt_pkt_cnt;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_sw_acc_mr_rsp_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sw_acc_mr_rsp_arbiter
//
// Cycle-by-cycle directed vectors for sw_acc_mr_rsp_arbiter. Each record holds
// one cycle of source/CEU inputs plus the readys and registered ceu_rsp_*
// expected in that same cycle. Source s drives head {s+1, 0.., 1} and data
// {.., s+1, cycle}, so an output beat identifies its source and the cycle it
// was accepted in.
// -----------------------------------------------------------------------------
module tb_sw_acc_mr_rsp_arbiter;
  localparam int HW = 128;
  localparam int DW = 256;
  localparam int CW = 32;

  logic          clk;
  logic          rst;
  logic          mpt_rsp_valid, mtt_rsp_valid, mapping_rsp_valid;
  logic          mpt_rsp_last, mtt_rsp_last, mapping_rsp_last;
  logic [HW-1:0] mpt_rsp_head, mtt_rsp_head, mapping_rsp_head;
  logic [DW-1:0] mpt_rsp_data, mtt_rsp_data, mapping_rsp_data;
  logic          mpt_rsp_ready, mtt_rsp_ready, mapping_rsp_ready;
  logic          ceu_rsp_valid, ceu_rsp_last, ceu_rsp_ready;
  logic [HW-1:0] ceu_rsp_head;
  logic [DW-1:0] ceu_rsp_data;
`ifdef SW_ACC_MR_RSP_CNT_EN
  logic [CW-1:0] mpt_pkt_cnt, mtt_pkt_cnt, mapping_pkt_cnt;
`endif

  sw_acc_mr_rsp_arbiter #(.HEAD_WIDTH(HW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .mpt_rsp_valid(mpt_rsp_valid), .mpt_rsp_head(mpt_rsp_head), .mpt_rsp_last(mpt_rsp_last),
    .mpt_rsp_data(mpt_rsp_data), .mpt_rsp_ready(mpt_rsp_ready),
    .mtt_rsp_valid(mtt_rsp_valid), .mtt_rsp_head(mtt_rsp_head), .mtt_rsp_last(mtt_rsp_last),
    .mtt_rsp_data(mtt_rsp_data), .mtt_rsp_ready(mtt_rsp_ready),
    .mapping_rsp_valid(mapping_rsp_valid), .mapping_rsp_head(mapping_rsp_head),
    .mapping_rsp_last(mapping_rsp_last), .mapping_rsp_data(mapping_rsp_data),
    .mapping_rsp_ready(mapping_rsp_ready),
    .ceu_rsp_valid(ceu_rsp_valid), .ceu_rsp_head(ceu_rsp_head), .ceu_rsp_last(ceu_rsp_last),
    .ceu_rsp_data(ceu_rsp_data), .ceu_rsp_ready(ceu_rsp_ready)
`ifdef SW_ACC_MR_RSP_CNT_EN
    , .mpt_pkt_cnt(mpt_pkt_cnt), .mtt_pkt_cnt(mtt_pkt_cnt), .mapping_pkt_cnt(mapping_pkt_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // v/l/rdy bit order: [0]=MPT [1]=MTT [2]=MAP.
  // pay=1: compare ceu head/last/data; src=0 means all-zero payload expected.
  typedef struct packed {
    logic       rst;
    logic [2:0] v;
    logic [2:0] l;
    logic       cr;
    logic [2:0] rdy;
    logic       ov;
    logic       pay;
    logic       ol;
    logic [1:0] src;
    logic [7:0] idx;
  } vec_t;

  localparam int NVEC = 37;
  vec_t tbl [NVEC];
  int   cyc;
  int   n_tests;
  int   n_fail;

  function automatic logic [HW-1:0] head_of(input logic [1:0] s);
    logic [HW-1:0] h;
    h = '0;
    if (s != 2'd0) h = {2'b00, s, {(HW-8){1'b0}}, 4'd1};
    return h;
  endfunction

  function automatic logic [DW-1:0] data_of(input logic [1:0] s, input logic [7:0] i);
    logic [DW-1:0] d;
    d = '0;
    if (s != 2'd0) d = {{(DW-16){1'b0}}, 6'd0, s, i};
    return d;
  endfunction

  task automatic step(input vec_t t, input string name);
    logic [7:0] tag;
    @(posedge clk);
    #1;
    tag               = 8'(cyc);
    rst               = t.rst;
    ceu_rsp_ready     = t.cr;
    mpt_rsp_valid     = t.v[0];
    mtt_rsp_valid     = t.v[1];
    mapping_rsp_valid = t.v[2];
    mpt_rsp_last      = t.l[0];
    mtt_rsp_last      = t.l[1];
    mapping_rsp_last  = t.l[2];
    mpt_rsp_head      = head_of(2'd1);
    mtt_rsp_head      = head_of(2'd2);
    mapping_rsp_head  = head_of(2'd3);
    mpt_rsp_data      = data_of(2'd1, tag);
    mtt_rsp_data      = data_of(2'd2, tag);
    mapping_rsp_data  = data_of(2'd3, tag);
    #4;
    n_tests++;
    if ({mapping_rsp_ready, mtt_rsp_ready, mpt_rsp_ready, ceu_rsp_valid} !== {t.rdy, t.ov}) begin
      n_fail++;
      $display("FAIL %s cyc %0d ctl: got rdy=%b valid=%b, expected rdy=%b valid=%b", name, cyc,
               {mapping_rsp_ready, mtt_rsp_ready, mpt_rsp_ready}, ceu_rsp_valid, t.rdy, t.ov);
    end
    if (t.pay) begin
      n_tests++;
      if (ceu_rsp_head !== head_of(t.src) || ceu_rsp_data !== data_of(t.src, t.idx) ||
          ceu_rsp_last !== t.ol) begin
        n_fail++;
        $display("FAIL %s cyc %0d payload: got head=%h last=%b data_lo=%h, expected head=%h last=%b data_lo=%h",
                 name, cyc, ceu_rsp_head, ceu_rsp_last, ceu_rsp_data[15:0],
                 head_of(t.src), t.ol, data_of(t.src, t.idx)[15:0]);
      end
    end
    cyc++;
  endtask

`ifdef SW_ACC_MR_RSP_CNT_EN
  task automatic check_cnt(input logic [CW-1:0] e0, input logic [CW-1:0] e1,
                           input logic [CW-1:0] e2, input string name);
    n_tests++;
    if ({mpt_pkt_cnt, mtt_pkt_cnt, mapping_pkt_cnt} !== {e0, e1, e2}) begin
      n_fail++;
      $display("FAIL %s: got cnt=%0d/%0d/%0d, expected %0d/%0d/%0d", name,
               mpt_pkt_cnt, mtt_pkt_cnt, mapping_pkt_cnt, e0, e1, e2);
    end
  endtask
`endif

  initial begin
    cyc     = 0;
    n_tests = 0;
    n_fail  = 0;
    rst               = 1'b0;
    ceu_rsp_ready     = 1'b0;
    mpt_rsp_valid     = 1'b0;
    mtt_rsp_valid     = 1'b0;
    mapping_rsp_valid = 1'b0;
    mpt_rsp_last      = 1'b0;
    mtt_rsp_last      = 1'b0;
    mapping_rsp_last  = 1'b0;
    mpt_rsp_head      = '0;
    mtt_rsp_head      = '0;
    mapping_rsp_head  = '0;
    mpt_rsp_data      = '0;
    mtt_rsp_data      = '0;
    mapping_rsp_data  = '0;

    //             rst  v       l       cr    rdy     ov    pay   ol    src   idx
    // Reset held with every source valid.
    tbl[0]  = '{1'b0, 3'b111, 3'b000, 1'b1, 3'b000, 1'b0, 1'b1, 1'b0, 2'd0, 8'd0};
    tbl[1]  = '{1'b0, 3'b111, 3'b000, 1'b1, 3'b000, 1'b0, 1'b1, 1'b0, 2'd0, 8'd0};
    tbl[2]  = '{1'b0, 3'b111, 3'b000, 1'b1, 3'b000, 1'b0, 1'b1, 1'b0, 2'd0, 8'd0};
    // All three post 2-beat packets; MPT reposts a 1-beat packet right away.
    tbl[3]  = '{1'b1, 3'b111, 3'b000, 1'b1, 3'b000, 1'b0, 1'b1, 1'b0, 2'd0, 8'd0};
    tbl[4]  = '{1'b1, 3'b111, 3'b000, 1'b1, 3'b001, 1'b0, 1'b1, 1'b0, 2'd0, 8'd0};
    tbl[5]  = '{1'b1, 3'b111, 3'b001, 1'b1, 3'b001, 1'b1, 1'b1, 1'b0, 2'd1, 8'd4};
    tbl[6]  = '{1'b1, 3'b111, 3'b001, 1'b1, 3'b000, 1'b1, 1'b1, 1'b1, 2'd1, 8'd5};
    tbl[7]  = '{1'b1, 3'b111, 3'b001, 1'b1, 3'b010, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0};
    tbl[8]  = '{1'b1, 3'b111, 3'b011, 1'b1, 3'b010, 1'b1, 1'b1, 1'b0, 2'd2, 8'd7};
    tbl[9]  = '{1'b1, 3'b101, 3'b001, 1'b1, 3'b000, 1'b1, 1'b1, 1'b1, 2'd2, 8'd8};
    tbl[10] = '{1'b1, 3'b101, 3'b001, 1'b1, 3'b100, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0};
    tbl[11] = '{1'b1, 3'b101, 3'b101, 1'b1, 3'b100, 1'b1, 1'b1, 1'b0, 2'd3, 8'd10};
    tbl[12] = '{1'b1, 3'b001, 3'b001, 1'b1, 3'b000, 1'b1, 1'b1, 1'b1, 2'd3, 8'd11};
    tbl[13] = '{1'b1, 3'b001, 3'b001, 1'b1, 3'b001, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0};
    tbl[14] = '{1'b1, 3'b000, 3'b000, 1'b1, 3'b000, 1'b1, 1'b1, 1'b1, 2'd1, 8'd13};
    // MTT 4-beat packet with CEU ready 1,0,0,1.
    tbl[15] = '{1'b1, 3'b010, 3'b000, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0};
    tbl[16] = '{1'b1, 3'b010, 3'b000, 1'b1, 3'b010, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0};
    tbl[17] = '{1'b1, 3'b010, 3'b000, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 2'd2, 8'd16};
    tbl[18] = '{1'b1, 3'b010, 3'b000, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 2'd2, 8'd16};
    tbl[19] = '{1'b1, 3'b010, 3'b000, 1'b1, 3'b010, 1'b1, 1'b1, 1'b0, 2'd2, 8'd16};
    tbl[20] = '{1'b1, 3'b010, 3'b000, 1'b1, 3'b010, 1'b1, 1'b1, 1'b0, 2'd2, 8'd19};
    tbl[21] = '{1'b1, 3'b010, 3'b010, 1'b1, 3'b010, 1'b1, 1'b1, 1'b0, 2'd2, 8'd20};
    tbl[22] = '{1'b1, 3'b000, 3'b000, 1'b1, 3'b000, 1'b1, 1'b1, 1'b1, 2'd2, 8'd21};
    // Single-beat MAP packet.
    tbl[23] = '{1'b1, 3'b100, 3'b100, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0};
    tbl[24] = '{1'b1, 3'b100, 3'b100, 1'b1, 3'b100, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0};
    tbl[25] = '{1'b1, 3'b000, 3'b000, 1'b1, 3'b000, 1'b1, 1'b1, 1'b1, 2'd3, 8'd24};
    tbl[26] = '{1'b1, 3'b000, 3'b000, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0};
    // MPT packet with a 3-cycle valid gap while MAP waits.
    tbl[27] = '{1'b1, 3'b101, 3'b100, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0};
    tbl[28] = '{1'b1, 3'b101, 3'b100, 1'b1, 3'b001, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0};
    tbl[29] = '{1'b1, 3'b100, 3'b100, 1'b1, 3'b001, 1'b1, 1'b1, 1'b0, 2'd1, 8'd28};
    tbl[30] = '{1'b1, 3'b100, 3'b100, 1'b1, 3'b001, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0};
    tbl[31] = '{1'b1, 3'b100, 3'b100, 1'b1, 3'b001, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0};
    tbl[32] = '{1'b1, 3'b101, 3'b101, 1'b1, 3'b001, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0};
    tbl[33] = '{1'b1, 3'b100, 3'b100, 1'b1, 3'b000, 1'b1, 1'b1, 1'b1, 2'd1, 8'd32};
    tbl[34] = '{1'b1, 3'b100, 3'b100, 1'b1, 3'b100, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0};
    tbl[35] = '{1'b1, 3'b000, 3'b000, 1'b1, 3'b000, 1'b1, 1'b1, 1'b1, 2'd3, 8'd34};
    tbl[36] = '{1'b1, 3'b000, 3'b000, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0};

    // One unchecked reset cycle so the DUT starts from a known state.
    @(posedge clk);
    #1;

    for (int i = 0; i < NVEC; i++) begin
      step(tbl[i], "table");
    end

`ifdef SW_ACC_MR_RSP_CNT_EN
    check_cnt(32'd3, 32'd2, 32'd3, "cnt_before_reset");
`endif

    // Reset during beat 2 of an MTT packet; afterwards all three request and
    // the restored pointer must pick MPT (MAP would win without it).
    step('{1'b1, 3'b010, 3'b000, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0}, "rst_mid");
    step('{1'b1, 3'b010, 3'b000, 1'b1, 3'b010, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0}, "rst_mid");
    step('{1'b0, 3'b010, 3'b000, 1'b1, 3'b010, 1'b1, 1'b1, 1'b0, 2'd2, 8'd38}, "rst_mid");
    step('{1'b1, 3'b111, 3'b101, 1'b1, 3'b000, 1'b0, 1'b1, 1'b0, 2'd0, 8'd0}, "rst_mid");
`ifdef SW_ACC_MR_RSP_CNT_EN
    check_cnt(32'd0, 32'd0, 32'd0, "cnt_after_reset");
`endif
    step('{1'b1, 3'b111, 3'b101, 1'b1, 3'b001, 1'b0, 1'b1, 1'b0, 2'd0, 8'd0}, "rst_mid");
    step('{1'b1, 3'b110, 3'b100, 1'b1, 3'b000, 1'b1, 1'b1, 1'b1, 2'd1, 8'd41}, "rst_mid");
`ifdef SW_ACC_MR_RSP_CNT_EN
    check_cnt(32'd1, 32'd0, 32'd0, "cnt_mpt_one");
`endif
    step('{1'b1, 3'b110, 3'b100, 1'b1, 3'b010, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0}, "rst_mid");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
